// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the conv2 / max-pool datapath.
//   WIDTH_BIT    : default signed pixel width shared with conv2
//   pix_t        : signed pixel type
//   pool_state_t : row-phase FSM states of the 2x2 pooling stage
//   smax()       : signed maximum of two pixels
package conv_pkg;

    localparam int WIDTH_BIT = 16;

    typedef logic signed [WIDTH_BIT-1:0] pix_t;

    typedef enum logic [1:0] {
        EVEN_ROW = 2'd0,
        ODD_ROW  = 2'd1,
        DROP_ROW = 2'd2
    } pool_state_t;

    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: half-width line buffer for the 2x2 pooling stage.
// Holds one horizontal pair-max per pooled column of the even row so the
// following odd row can finish each 2x2 window.
// Ports:
//   clock : rising-edge clock
//   we    : write enable
//   waddr : write address (input col >> 1)
//   wdata : signed pair-max to store
//   raddr : asynchronous read address (input col >> 1)
//   rdata : signed stored pair-max
// Contents are not reset: every entry is written on the even row before
// the odd row reads it.
module pool_line_buf #(
    parameter int DEPTH = 127,
    parameter int AW    = 7,
    parameter int WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic signed [WIDTH-1:0] wdata,
    input  logic [AW-1:0]           raddr,
    output logic signed [WIDTH-1:0] rdata
);

    logic signed [WIDTH-1:0] mem_q [DEPTH];
    logic signed [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_maxpool2x2.sv
// conv_maxpool2x2: streaming 2x2 stride-2 max-pool stage behind conv2.
// Input is an IN_H x IN_W raster of signed pixels; output is the
// floor(IN_H/2) x floor(IN_W/2) pooled raster.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   in_valid / in_ready / in_data       : input pixel stream
//   out_valid / out_ready / out_data    : pooled pixel stream
//   out_last   : marks the final pooled pixel of a frame
//   frame_done : one-cycle pulse after the final pooled pixel transfers
// Handshake: a beat moves when valid && ready on the rising edge; a source
// holds data stable while valid is high and ready is low.
// Build option: define CONV_MAXPOOL_RELU_EN to clamp negative pooled
// results to zero before the output register.
module conv_maxpool2x2 #(
    parameter int IN_W      = 254,
    parameter int IN_H      = 254,
    parameter int WIDTH_BIT = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH_BIT-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_BIT-1:0] out_data,
    output logic                        out_last,
    output logic                        frame_done
);

    import conv_pkg::*;

    localparam int CW    = $clog2(IN_W);
    localparam int RW    = $clog2(IN_H);
    localparam int DEPTH = IN_W / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit ODD_W = (IN_W % 2) == 1;
    localparam bit ODD_H = (IN_H % 2) == 1;

    localparam logic [CW-1:0] COL_END  = CW'(IN_W - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(IN_H - 1);
    // Bottom-right input pixel of the last complete 2x2 window.
    localparam logic [CW-1:0] LAST_COL = CW'((IN_W / 2) * 2 - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'((IN_H / 2) * 2 - 1);

    pool_state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    pix_t          hreg_q, hreg_d;
    pix_t          out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          frame_done_q, frame_done_d;

    pix_t          pix_in;
    pix_t          pair_max;
    pix_t          pool_max;
    pix_t          result;
    pix_t          lb_rdata;
    logic [AW-1:0] lb_addr;
    logic          lb_we;
    logic          accept;
    logic          xfer;
    logic          end_of_row;
    logic          odd_col;
    logic          trailing_col;
    logic          new_result;
    logic          new_last;

    assign pix_in       = in_data;
    assign in_ready     = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign xfer         = out_valid_q && out_ready;
    assign end_of_row   = (col_q == COL_END);
    assign odd_col      = col_q[0];
    // With odd IN_W the last pixel of a row (even col) has no partner.
    assign trailing_col = ODD_W && end_of_row;
    assign lb_addr      = AW'(col_q >> 1);
    assign pair_max     = smax(hreg_q, pix_in);
    assign pool_max     = smax(lb_rdata, pair_max);

    always_comb begin
        result = pool_max;
`ifdef CONV_MAXPOOL_RELU_EN
        if (pool_max < 0) begin
            result = '0;
        end
`endif
    end

    pool_line_buf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (WIDTH_BIT)
    ) u_line_buf (
        .clock (clock),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair_max),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    // Position counters and row-phase FSM; everything advances on accept.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        hreg_d     = hreg_q;
        lb_we      = 1'b0;
        new_result = 1'b0;
        new_last   = 1'b0;
        if (accept) begin
            if (end_of_row) begin
                col_d = '0;
                row_d = (row_q == ROW_END) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            case (state_q)
                EVEN_ROW: begin
                    if (odd_col) begin
                        lb_we = 1'b1;
                    end else if (!trailing_col) begin
                        hreg_d = pix_in;
                    end
                    if (end_of_row) begin
                        state_d = ODD_ROW;
                    end
                end
                ODD_ROW: begin
                    if (odd_col) begin
                        new_result = 1'b1;
                        new_last   = (row_q == LAST_ROW) && (col_q == LAST_COL);
                    end else if (!trailing_col) begin
                        hreg_d = pix_in;
                    end
                    if (end_of_row) begin
                        // Odd IN_H leaves an unpaired last row to discard.
                        state_d = (ODD_H && row_d == ROW_END) ? DROP_ROW : EVEN_ROW;
                    end
                end
                DROP_ROW: begin
                    if (end_of_row) begin
                        state_d = EVEN_ROW;
                    end
                end
                default: state_d = EVEN_ROW;
            endcase
        end
    end

    // Output register: a new result may load in the same cycle the old one
    // transfers, since in_ready already accounts for out_ready.
    always_comb begin
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        out_last_d   = xfer ? 1'b0 : out_last_q;
        frame_done_d = xfer && out_last_q;
        if (new_result) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_last_d  = new_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= EVEN_ROW;
            col_q        <= '0;
            row_q        <= '0;
            hreg_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hreg_q       <= hreg_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_maxpool2x2.sv
module tb_conv_maxpool2x2;

  typedef int iq_t[$];

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic               in_valid4, in_ready4, out_valid4, out_ready4, out_last4, frame_done4;
  logic signed [15:0] in_data4, out_data4;
  logic               in_valid5, in_ready5, out_valid5, out_ready5, out_last5, frame_done5;
  logic signed [15:0] in_data5, out_data5;

  conv_maxpool2x2 #(.IN_W(4), .IN_H(4), .WIDTH_BIT(16)) u_dut4 (
    .clock(clk), .reset(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_last(out_last4), .frame_done(frame_done4)
  );

  conv_maxpool2x2 #(.IN_W(5), .IN_H(5), .WIDTH_BIT(16)) u_dut5 (
    .clock(clk), .reset(rst),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .out_last(out_last5), .frame_done(frame_done5)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int acc4 = 0, acc5 = 0;
  int n_done4 = 0, n_done5 = 0;
  int stall_cycles4 = 0;

  logic [16:0] exp4_q[$];   // {last, data}
  logic [16:0] exp5_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int model_q[$];

  function automatic int rl(input int v);
`ifdef CONV_MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Max of every complete 2x2 window, in raster order.
  function automatic void run_model(input int w, input int h, input iq_t pix);
    model_q.delete();
    for (int pr = 0; pr < h / 2; pr++) begin
      for (int pc = 0; pc < w / 2; pc++) begin
        int m;
        m = pix[(2 * pr) * w + 2 * pc];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (pix[(2 * pr + dr) * w + 2 * pc + dc] > m) m = pix[(2 * pr + dr) * w + 2 * pc + dc];
        model_q.push_back(rl(m));
      end
    end
  endfunction

  task automatic check_model(input iq_t lit);
    check("model_len", model_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < model_q.size(); i++)
      check("model_val", model_q[i], rl(lit[i]));
  endtask

  task automatic queue_model(input int which);
    for (int i = 0; i < model_q.size(); i++) begin
      logic [16:0] e;
      e = {(i == model_q.size() - 1), model_q[i][15:0]};
      if (which == 4) exp4_q.push_back(e);
      else exp5_q.push_back(e);
    end
  endtask

  function automatic iq_t ramp(input int n);
    iq_t q;
    for (int i = 1; i <= n; i++) q.push_back(i);
    return q;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int which, input int v);
    int  t;
    logic rdy;
    t = 0;
    if (which == 4) begin in_valid4 = 1'b1; in_data4 = 16'(v); end
    else begin in_valid5 = 1'b1; in_data5 = 16'(v); end
    forever begin
      @(negedge clk);
      rdy = (which == 4) ? in_ready4 : in_ready5;
      if (rdy) break;
      t++;
      if (t > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout dut%0d: in_ready got 0 expected 1", which);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (rdy) begin
      if (which == 4) acc4++; else acc5++;
    end
    if (which == 4) in_valid4 = 1'b0; else in_valid5 = 1'b0;
  endtask

  task automatic send_frame(input int which, input iq_t pix);
    foreach (pix[i]) send(which, pix[i]);
  endtask

  task automatic drain(input int which);
    int t;
    t = 0;
    while (((which == 4) ? exp4_q.size() : exp5_q.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (((which == 4) ? exp4_q.size() : exp5_q.size()) != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout dut%0d: outstanding %0d expected 0", which,
               (which == 4) ? exp4_q.size() : exp5_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_in_ready4", in_ready4, 1);
    check("rst_out_valid4", out_valid4, 0);
    check("rst_out_data4", out_data4, 0);
    check("rst_out_last4", out_last4, 0);
    check("rst_frame_done4", frame_done4, 0);
    check("rst_out_valid5", out_valid5, 0);
  endtask

  // ---------------- scoreboard / compare processes ----------------
  logic               stall_prev4 = 1'b0;
  logic signed [15:0] held_data4;
  logic               held_last4;
  logic               done_pend4 = 1'b0;
  logic               done_pend5 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev4 = 1'b0;
      done_pend4  = 1'b0;
    end else begin
      if (stall_prev4) begin
        check("hold_valid4", out_valid4, 1);
        check("hold_data4", out_data4, held_data4);
        check("hold_last4", out_last4, held_last4);
      end
      if (out_valid4 && !out_ready4) begin
        stall_cycles4++;
        check("stall_in_ready4", in_ready4, 0);
      end
      stall_prev4 = out_valid4 && !out_ready4;
      held_data4  = out_data4;
      held_last4  = out_last4;
      if (frame_done4 || done_pend4) check("frame_done4", frame_done4, done_pend4);
      if (frame_done4) n_done4++;
      done_pend4 = 1'b0;
      if (out_valid4 && out_ready4) begin
        if (exp4_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out4_extra: got data %0d expected no output", out_data4);
        end else begin
          logic [16:0] e;
          e = exp4_q.pop_front();
          check("out4_data", out_data4, int'($signed(e[15:0])));
          check("out4_last", out_last4, e[16]);
          done_pend4 = e[16];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      done_pend5 = 1'b0;
    end else begin
      if (frame_done5 || done_pend5) check("frame_done5", frame_done5, done_pend5);
      if (frame_done5) n_done5++;
      done_pend5 = 1'b0;
      if (out_valid5 && out_ready5) begin
        if (exp5_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out5_extra: got data %0d expected no output", out_data5);
        end else begin
          logic [16:0] e;
          e = exp5_q.pop_front();
          check("out5_data", out_data5, int'($signed(e[15:0])));
          check("out5_last", out_last5, e[16]);
          done_pend5 = e[16];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic stall_after_first();
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!out_valid4 && t < 100);
    out_ready4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready4 = 1'b1;
  endtask

  iq_t frame;

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
    in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();
    @(posedge clk);
    #1;

    // 4x4 ramp
    frame = ramp(16);
    run_model(4, 4, frame);
    check_model('{6, 8, 14, 16});
    queue_model(4);
    send_frame(4, frame);
    drain(4);
    check("frames_after_ramp4", n_done4, 1);

    // 4x4 ramp with a 3-cycle downstream stall after the first output
    run_model(4, 4, frame);
    queue_model(4);
    stall_cycles4 = 0;
    fork
      send_frame(4, frame);
      stall_after_first();
    join
    drain(4);
    check("stall_cycles4", stall_cycles4, 3);

    // all -5
    frame.delete();
    for (int i = 0; i < 16; i++) frame.push_back(-5);
    run_model(4, 4, frame);
    check_model('{-5, -5, -5, -5});
    queue_model(4);
    send_frame(4, frame);
    drain(4);

    // signed extremes
    frame = '{-32768, 32767, -32768, -32768,
              -1,     0,     -32768, -2,
              100,    -100,  3,      7,
              -7,     50,    7,      -9};
    run_model(4, 4, frame);
    check_model('{32767, -2, 100, 7});
    queue_model(4);
    send_frame(4, frame);
    drain(4);

    // reset after 6 pixels, then a clean frame
    frame = ramp(16);
    for (int i = 0; i < 6; i++) send(4, frame[i]);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();
    @(posedge clk);
    #1;
    run_model(4, 4, frame);
    queue_model(4);
    send_frame(4, frame);
    drain(4);
    check("frames_total4", n_done4, 5);

    // 5x5 ramp: odd width and height
    frame = ramp(25);
    run_model(5, 5, frame);
    check_model('{7, 9, 17, 19});
    queue_model(5);
    acc5 = 0;
    send_frame(5, frame);
    drain(5);
    check("accepted5", acc5, 25);
    check("frames_total5", n_done5, 1);

    check("leftover4", exp4_q.size(), 0);
    check("leftover5", exp5_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
